// File: rtl/fpu_bus_pkg.sv
// ============================================================================
//  fpu_bus_pkg : FPU slave register map, command codes and master FSM states
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_bus_pkg;

  localparam logic [1:0] FPU_ADDR_STATUS = 2'b00;
  localparam logic [1:0] FPU_ADDR_RESULT = 2'b01;
  localparam logic [1:0] FPU_ADDR_CMD    = 2'b10;
  localparam logic [1:0] FPU_ADDR_VALUE  = 2'b11;

  localparam logic [7:0] FPU_CMD_SETY = 8'd1;
  localparam logic [7:0] FPU_CMD_SETX = 8'd2;
  localparam logic [7:0] FPU_CMD_DIV  = 8'd3;
  localparam logic [7:0] FPU_CMD_MUL  = 8'd4;

  localparam int FPU_STAT_BUSY_BIT = 7;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD_Y  = 4'd1,
    ST_VAL_Y  = 4'd2,
    ST_CMD_X  = 4'd3,
    ST_VAL_X  = 4'd4,
    ST_CMD_OP = 4'd5,
    ST_GAP    = 4'd6,
    ST_POLL   = 4'd7,
    ST_READ   = 4'd8,
    ST_FIN    = 4'd9
  } fpu_state_e;

  // Byte idx of a 32-bit word counted from the MSB end.
  function automatic logic [7:0] fpu_byte_msb(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_bus_cycle.sv
// ============================================================================
//  fpu_bus_cycle : one two-cycle STROBE/RECOVER access on the FPU byte bus
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_bus_cycle
  import fpu_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_i,
  input  logic       wr_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] rdata_i,
  output logic       ack_o,
  output logic [7:0] rdata_o,
  output logic       FPUsel_o,
  output logic [1:0] addr_o,
  output logic       read_o,
  output logic       write_o,
  output logic [7:0] wdata_o
);

  logic       recover_q, recover_d;
  logic [7:0] rdata_q, rdata_d;
  logic       w_strobe;

  // The requester holds req through RECOVER; the strobe only exists in the first cycle.
  assign w_strobe = req_i && !recover_q;

  always_comb begin
    recover_d = w_strobe;
    rdata_d   = rdata_q;
    if (w_strobe && !wr_i) begin
      rdata_d = rdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      recover_q <= 1'b0;
      rdata_q   <= 8'd0;
    end else begin
      recover_q <= recover_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ack_o    = recover_q;
  assign rdata_o  = rdata_q;
  assign FPUsel_o = w_strobe;
  assign read_o   = w_strobe && !wr_i;
  assign write_o  = w_strobe && wr_i;
  assign addr_o   = w_strobe ? addr_i : 2'b00;
  assign wdata_o  = (w_strobe && wr_i) ? wdata_i : 8'd0;

endmodule

`default_nettype wire

// File: rtl/fpu_master.sv
// ============================================================================
//  fpu_master : bus initiator that loads Y/X, issues an op, polls and reads
//               the 32-bit result from the memory-mapped FPU slave
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_master
  import fpu_bus_pkg::*;
#(
  parameter int unsigned GAP_CYC    = 2,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] y_in,
  input  logic [31:0] x_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic        FPUsel,
  output logic [1:0]  addr,
  output logic        read,
  output logic        write,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  fpu_state_e         state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         poll_q, poll_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [31:0]        y_q, y_d, x_q, x_d;
  logic               op_q, op_d;
  logic [31:0]        asm_q, asm_d;
  logic [31:0]        result_q, result_d;
  logic               err_q, err_d;

  logic               w_req, w_wr, w_ack;
  logic [1:0]         w_addr;
  logic [7:0]         w_wdata, w_rdata;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
    y_d      = y_q;
    x_d      = x_q;
    op_d     = op_q;
    asm_d    = asm_q;
    result_d = result_q;
    err_d    = err_q;
    w_req    = 1'b0;
    w_wr     = 1'b1;
    w_addr   = FPU_ADDR_STATUS;
    w_wdata  = 8'd0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          y_d     = y_in;
          x_d     = x_in;
          op_d    = op;
          err_d   = 1'b0;
          idx_d   = 2'd0;
          state_d = ST_CMD_Y;
        end
      end
      ST_CMD_Y: begin
        w_req   = 1'b1;
        w_addr  = FPU_ADDR_CMD;
        w_wdata = FPU_CMD_SETY;
        if (w_ack) state_d = ST_VAL_Y;
      end
      ST_VAL_Y: begin
        w_req   = 1'b1;
        w_addr  = FPU_ADDR_VALUE;
        w_wdata = fpu_byte_msb(y_q, idx_q);
        if (w_ack) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_CMD_X;
        end
      end
      ST_CMD_X: begin
        w_req   = 1'b1;
        w_addr  = FPU_ADDR_CMD;
        w_wdata = FPU_CMD_SETX;
        if (w_ack) state_d = ST_VAL_X;
      end
      ST_VAL_X: begin
        w_req   = 1'b1;
        w_addr  = FPU_ADDR_VALUE;
        w_wdata = fpu_byte_msb(x_q, idx_q);
        if (w_ack) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_CMD_OP;
        end
      end
      ST_CMD_OP: begin
        w_req   = 1'b1;
        w_addr  = FPU_ADDR_CMD;
        w_wdata = op_q ? FPU_CMD_MUL : FPU_CMD_DIV;
        poll_d  = 8'd0;
        gap_d   = '0;
        if (w_ack) state_d = ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          gap_d   = '0;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        w_req  = 1'b1;
        w_wr   = 1'b0;
        w_addr = FPU_ADDR_STATUS;
        if (w_ack) begin
          poll_d = poll_q + 8'd1;
          if (!w_rdata[FPU_STAT_BUSY_BIT]) begin
            idx_d   = 2'd0;
            state_d = ST_READ;
          end else if (poll_q + 8'd1 == 8'(POLL_LIMIT)) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_READ: begin
        w_req  = 1'b1;
        w_wr   = 1'b0;
        w_addr = FPU_ADDR_RESULT;
        if (w_ack) begin
          asm_d = {asm_q[23:0], w_rdata};
          idx_d = idx_q + 2'd1;
          // Publish only a complete word so result never shows a partial value.
          if (idx_q == 2'd3) begin
            result_d = {asm_q[23:0], w_rdata};
            state_d  = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      poll_q   <= 8'd0;
      gap_q    <= '0;
      y_q      <= 32'd0;
      x_q      <= 32'd0;
      op_q     <= 1'b0;
      asm_q    <= 32'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
      y_q      <= y_d;
      x_q      <= x_d;
      op_q     <= op_d;
      asm_q    <= asm_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  fpu_bus_cycle u_bus (
    .clk      (clk),
    .reset    (reset),
    .req_i    (w_req),
    .wr_i     (w_wr),
    .addr_i   (w_addr),
    .wdata_i  (w_wdata),
    .rdata_i  (rdata),
    .ack_o    (w_ack),
    .rdata_o  (w_rdata),
    .FPUsel_o (FPUsel),
    .addr_o   (addr),
    .read_o   (read),
    .write_o  (write),
    .wdata_o  (wdata)
  );

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done   = (state_q == ST_FIN);
  assign err    = err_q;
  assign result = result_q;

endmodule

`default_nettype wire
